// File: rtl/pong_pkg.sv
// Shared encodings and sizing helpers for the ball motion engine and its
// paddle-zone detector.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_SCORED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ZONE_TOP = 2'b00,
        ZONE_MID = 2'b01,
        ZONE_BOT = 2'b10
    } zone_t;

    // Bits needed to hold coordinates / speeds in [0, max_val].
    function automatic int coord_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    // Counter width that can reach max_count and never collapses to zero bits.
    function automatic int count_width(input int max_count);
        return $clog2(max_count + 2);
    endfunction

endpackage

// File: rtl/paddle_zone_detect.sv
// Paddle overlap test and impact-zone classification for one paddle, based on
// the ball's pre-move vertical position.
module paddle_zone_detect
    import pong_pkg::*;
#(
    parameter int YW            = 10,
    parameter int PADDLE_HEIGHT = 15,
    parameter int Y_BOXSIZE     = 4
) (
    input  logic [YW-1:0] ball_y,
    input  logic [YW-1:0] paddle_y,
    output logic          hit,
    output logic [1:0]    zone
);

    localparam int THIRD = PADDLE_HEIGHT / 3;
    localparam int RW    = YW + 2;

    logic [RW-1:0] by;
    logic [RW-1:0] py;
    logic [RW-1:0] centre;
    logic [RW-1:0] rel;

    assign by     = RW'(ball_y);
    assign py     = RW'(paddle_y);
    assign centre = by + RW'(Y_BOXSIZE / 2);

    // Both sides written as additions so nothing can underflow.
    assign hit = (by < py + RW'(PADDLE_HEIGHT)) && (by + RW'(Y_BOXSIZE) > py);
    assign rel = (centre > py) ? centre - py : '0;

    always_comb begin
        zone = ZONE_MID;
        if (rel < RW'(THIRD))
            zone = ZONE_TOP;
        else if (rel >= RW'(PADDLE_HEIGHT - THIRD))
            zone = ZONE_BOT;
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Registered pong ball engine: wall bounce, paddle deflection with speed-up,
// and a serve state machine with a frame-counted relaunch delay.
module ball_motion_engine
    import pong_pkg::*;
#(
    parameter int X_MAX         = 640,
    parameter int Y_MIN         = 20,
    parameter int Y_MAX         = 480,
    parameter int X_BOXSIZE     = 4,
    parameter int Y_BOXSIZE     = 4,
    parameter int PADDLE_WIDTH  = 4,
    parameter int PADDLE_HEIGHT = 15,
    parameter int PADDLE_OFFSET = 2,
    parameter int RATE          = 1,
    parameter int MAX_RATE      = 15,
    parameter int SPEEDUP       = 1,
    parameter int SERVE_DELAY   = 30,
    parameter int AUTO_SERVE    = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       frame_tick,
    input  logic                       serve,
    input  logic [$clog2(Y_MAX):0]     left_paddle_y,
    input  logic [$clog2(Y_MAX):0]     right_paddle_y,
    output logic [$clog2(X_MAX):0]     ball_x,
    output logic [$clog2(Y_MAX):0]     ball_y,
    output logic [$clog2(X_MAX):0]     old_x,
    output logic [$clog2(Y_MAX):0]     old_y,
    output logic [$clog2(MAX_RATE):0]  vx,
    output logic [$clog2(MAX_RATE):0]  vy,
    output logic                       x_dir,
    output logic                       y_dir,
    output logic [1:0]                 state,
    output logic                       moved,
    output logic                       paddle_hit,
    output logic                       boundary_contact,
    output logic                       lhs_scored,
    output logic                       rhs_scored
);

    localparam int XW = coord_width(X_MAX);
    localparam int YW = coord_width(Y_MAX);
    localparam int VW = coord_width(MAX_RATE);
    localparam int CW = count_width(SERVE_DELAY);

    localparam logic [XW:0]   X_MIN_W   = (XW+1)'(PADDLE_WIDTH + PADDLE_OFFSET);
    localparam logic [XW:0]   X_RIGHT_W = (XW+1)'(X_MAX - PADDLE_WIDTH - PADDLE_OFFSET - X_BOXSIZE);
    localparam logic [YW:0]   Y_MIN_W   = (YW+1)'(Y_MIN);
    localparam logic [YW:0]   Y_BOT_W   = (YW+1)'(Y_MAX - Y_BOXSIZE);
    localparam logic [XW-1:0] X_CTR     = XW'(X_MAX / 2);
    localparam logic [YW-1:0] Y_CTR     = YW'(Y_MAX / 2);
    localparam logic [VW-1:0] V_SERVE   = VW'(RATE);
    localparam logic [VW:0]   V_MAX     = (VW+1)'(MAX_RATE);
    localparam logic [CW-1:0] DELAY_END = CW'(SERVE_DELAY);

    state_t        st;
    logic [CW-1:0] delay_cnt;
    logic          last_lhs;

    logic          l_hit, r_hit;
    logic [1:0]    l_zone, r_zone;

    paddle_zone_detect #(
        .YW(YW), .PADDLE_HEIGHT(PADDLE_HEIGHT), .Y_BOXSIZE(Y_BOXSIZE)
    ) u_left (
        .ball_y(ball_y), .paddle_y(left_paddle_y), .hit(l_hit), .zone(l_zone)
    );

    paddle_zone_detect #(
        .YW(YW), .PADDLE_HEIGHT(PADDLE_HEIGHT), .Y_BOXSIZE(Y_BOXSIZE)
    ) u_right (
        .ball_y(ball_y), .paddle_y(right_paddle_y), .hit(r_hit), .zone(r_zone)
    );

    logic [XW:0]   bx, vx_x, x_fwd;
    logic [YW:0]   by, vy_y, y_fwd;
    logic [VW:0]   vx_sum, vy_sum;
    logic [VW-1:0] vx_up, vy_up, vy_down;
    logic          at_left, at_right, at_edge, side_hit, miss, y_wall;
    logic [1:0]    side_zone;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [VW-1:0] nvx, nvy;
    logic          nxd, nyd;

    // Everything is widened by one bit so sums cannot wrap before the compare.
    assign bx   = (XW+1)'(ball_x);
    assign vx_x = (XW+1)'(vx);
    assign by   = (YW+1)'(ball_y);
    assign vy_y = (YW+1)'(vy);

    assign vx_sum  = (VW+1)'(vx) + (VW+1)'(SPEEDUP);
    assign vy_sum  = (VW+1)'(vy) + (VW+1)'(1);
    assign vx_up   = (vx_sum > V_MAX) ? VW'(V_MAX) : VW'(vx_sum);
    assign vy_up   = (vy_sum > V_MAX) ? VW'(V_MAX) : VW'(vy_sum);
    assign vy_down = (vy > VW'(1)) ? vy - VW'(1) : VW'(1);

    assign at_left   = !x_dir && (bx < X_MIN_W + vx_x);
    assign at_right  =  x_dir && (bx + vx_x > X_RIGHT_W);
    assign at_edge   = at_left || at_right;
    assign side_hit  = at_left ? l_hit  : r_hit;
    assign side_zone = at_left ? l_zone : r_zone;
    assign miss      = at_edge && !side_hit;

    assign x_fwd = x_dir ? bx + vx_x : bx - vx_x;
    assign y_fwd = y_dir ? by + vy_y : by - vy_y;

    always_comb begin
        ny     = YW'(y_fwd);
        nyd    = y_dir;
        y_wall = 1'b0;
        if (y_dir && (y_fwd > Y_BOT_W)) begin
            ny     = YW'(Y_BOT_W);
            nyd    = 1'b0;
            y_wall = 1'b1;
        end else if (!y_dir && (by < Y_MIN_W + vy_y)) begin
            ny     = YW'(Y_MIN_W);
            nyd    = 1'b1;
            y_wall = 1'b1;
        end

        nx  = XW'(x_fwd);
        nxd = x_dir;
        nvx = vx;
        nvy = vy;
        if (at_edge) begin
            if (side_hit) begin
                nx  = at_left ? XW'(X_MIN_W) : XW'(X_RIGHT_W);
                nxd = !x_dir;
                nvx = vx_up;
                // Outer thirds steer and speed up; the middle third calms vy.
                case (side_zone)
                    ZONE_TOP: begin nvy = vy_up; nyd = 1'b0; end
                    ZONE_BOT: begin nvy = vy_up; nyd = 1'b1; end
                    default:  nvy = vy_down;
                endcase
            end else begin
                nx = ball_x;
            end
        end
    end

    assign state = st;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st               <= ST_IDLE;
            ball_x           <= X_CTR;
            ball_y           <= Y_CTR;
            old_x            <= X_CTR;
            old_y            <= Y_CTR;
            vx               <= V_SERVE;
            vy               <= V_SERVE;
            x_dir            <= 1'b1;
            y_dir            <= 1'b1;
            delay_cnt        <= '0;
            last_lhs         <= 1'b0;
            moved            <= 1'b0;
            paddle_hit       <= 1'b0;
            boundary_contact <= 1'b0;
            lhs_scored       <= 1'b0;
            rhs_scored       <= 1'b0;
        end else begin
            moved            <= 1'b0;
            paddle_hit       <= 1'b0;
            boundary_contact <= 1'b0;
            lhs_scored       <= 1'b0;
            rhs_scored       <= 1'b0;
            if (enable) begin
                case (st)
                    ST_IDLE: begin
                        ball_x <= X_CTR;
                        ball_y <= Y_CTR;
                        if (serve)
                            st <= ST_PLAY;
                    end
                    ST_PLAY: if (frame_tick) begin
                        old_x            <= ball_x;
                        old_y            <= ball_y;
                        ball_x           <= nx;
                        ball_y           <= ny;
                        x_dir            <= nxd;
                        y_dir            <= nyd;
                        vx               <= nvx;
                        vy               <= nvy;
                        moved            <= 1'b1;
                        paddle_hit       <= at_edge && side_hit;
                        boundary_contact <= y_wall && !miss;
                        lhs_scored       <= miss && at_right;
                        rhs_scored       <= miss && at_left;
                        if (miss) begin
                            st        <= ST_SCORED;
                            delay_cnt <= '0;
                            last_lhs  <= at_right;
                        end
                    end
                    ST_SCORED: if (frame_tick) begin
                        if (delay_cnt == DELAY_END) begin
                            old_x     <= ball_x;
                            old_y     <= ball_y;
                            ball_x    <= X_CTR;
                            ball_y    <= Y_CTR;
                            vx        <= V_SERVE;
                            vy        <= V_SERVE;
                            x_dir     <= !last_lhs;
                            y_dir     <= 1'b1;
                            moved     <= 1'b1;
                            delay_cnt <= '0;
                            st        <= (AUTO_SERVE != 0) ? ST_PLAY : ST_IDLE;
                        end else begin
                            delay_cnt <= delay_cnt + CW'(1);
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Parametrised successor to the single-rate ball controller. Merges direction control and position update into one registered engine.
- Independent x/y speed magnitudes, paddle-zone deflection, per-hit speed-up, and a serve state machine with a frame-counted serve delay.
- Sits between the frame-tick rate divider, the paddle controllers and the ball renderer/score keeper.

Parameters:
X_MAX, 640, right screen edge in pixels
Y_MIN, 20, top playfield edge (below the score bar)
Y_MAX, 480, bottom screen edge
X_BOXSIZE, 4, ball width
Y_BOXSIZE, 4, ball height
PADDLE_WIDTH, 4, paddle width
PADDLE_HEIGHT, 15, paddle height
PADDLE_OFFSET, 2, paddle gap from the screen edge
RATE, 1, serve speed on each axis
MAX_RATE, 15, per-axis speed ceiling
SPEEDUP, 1, vx increment per paddle hit
SERVE_DELAY, 30, frame ticks frozen after a score
AUTO_SERVE, 1, 1 = relaunch after the delay; 0 = wait in IDLE for serve

Ports:
- Widths: XW=$clog2(X_MAX)+1, YW=$clog2(Y_MAX)+1, VW=$clog2(MAX_RATE)+1.
- Port list:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  freeze when low
frame_tick  in  1  one-cycle frame strobe
serve  in  1  launch request, honoured only in IDLE
left_paddle_y  in  YW  top of left paddle
right_paddle_y  in  YW  top of right paddle
ball_x / ball_y  out  XW / YW  current ball top-left
old_x / old_y  out  XW / YW  position before the last move
vx / vy  out  VW  current speed magnitudes
x_dir / y_dir  out  1  x: 1 = right; y: 1 = down
state  out  2  00 IDLE, 01 PLAY, 10 SCORED
moved  out  1  pulse, position updated
paddle_hit / boundary_contact / lhs_scored / rhs_scored  out  1  one-cycle event pulses

Behaviour:
- Constants: X_MIN = PADDLE_WIDTH+PADDLE_OFFSET. X_RIGHT = X_MAX-PADDLE_WIDTH-PADDLE_OFFSET-X_BOXSIZE. Y_BOT = Y_MAX-Y_BOXSIZE. THIRD = PADDLE_HEIGHT/3.
- Reset (async, resetn=0):
  - ball = (X_MAX/2, Y_MAX/2); old = same.
  - vx = vy = RATE; x_dir = y_dir = 1; state = IDLE; all pulses 0; delay counter 0.
- enable=0: all registers hold, frame_tick and serve ignored, pulses 0.
- IDLE:
  - Ball held at centre.
  - serve=1 → PLAY next cycle. serve in PLAY or SCORED is ignored.
- PLAY, on frame_tick: all updates are registered and appear 1 cycle after the tick, alongside moved=1. old_* take the pre-move position.
- Vertical:
  - Down and ball_y+vy > Y_BOT → ball_y = Y_BOT, y_dir = 0, boundary_contact.
  - Up and ball_y < Y_MIN+vy → ball_y = Y_MIN, y_dir = 1, boundary_contact.
  - Otherwise ball_y ± vy.
- Horizontal:
  - Left and ball_x < X_MIN+vx → paddle check on the left paddle.
  - Right and ball_x > X_RIGHT-vx → paddle check on the right paddle.
  - Otherwise ball_x ± vx.
- Paddle check:
  - Overlap = (ball_y < py+PADDLE_HEIGHT) && (ball_y+Y_BOXSIZE > py). Uses pre-move ball_y; no subtraction, so no underflow.
  - Hit:
    - ball_x clamps to X_MIN (left) or X_RIGHT (right); x_dir flips; vx = min(vx+SPEEDUP, MAX_RATE); paddle_hit.
    - Zone: rel = ball_y + Y_BOXSIZE/2 - py, saturated at 0.
    - rel < THIRD → vy = min(vy+1, MAX_RATE), y_dir = 0.
    - rel ≥ PADDLE_HEIGHT-THIRD → vy = min(vy+1, MAX_RATE), y_dir = 1.
    - Otherwise vy = max(vy-1, 1) and y_dir keeps the vertical result.
    - Zone y_dir overrides the vertical-wall y_dir flip on the same tick; the wall clamp of ball_y still applies.
  - Miss on left → rhs_scored. Miss on right → lhs_scored. Either miss → SCORED; ball_x not moved that tick; boundary_contact suppressed that tick.
- SCORED:
  - Ball frozen; counter counts frame_ticks.
  - At count == SERVE_DELAY: ball to centre, old = previous, vx = vy = RATE, y_dir = 1, moved pulse, counter cleared.
  - x_dir = 0 after lhs_scored, 1 after rhs_scored.
  - Next state PLAY if AUTO_SERVE=1, else IDLE.
- Arithmetic: position sums are computed at width XW+1/YW+1 before compare, so no wrap. vx and vy never leave [1, MAX_RATE].

Decomposition:
- Package pong_pkg:
  - State encodings IDLE/PLAY/SCORED.
  - Zone encodings TOP/MID/BOT.
  - Width helper functions.
- Sub-module paddle_zone_detect (ball_y, paddle_y → hit, zone[1:0]), instantiated once per side.

Test Plan (default parameters, AUTO_SERVE=1):
1. Release reset → ball (320,240), IDLE, vx=vy=1. serve → PLAY. frame_tick → ball (321,241), old (320,240), moved=1.
2. ball_y=475, vy=2, down, frame_tick → ball_y=476, y_dir=0, boundary_contact high exactly 1 cycle.
3. ball_x=7, vx=2, left, ball_y=105, left_paddle_y=100 (rel 7, mid), vy=3 → ball_x=6, x_dir=1, vx=3, vy=2, paddle_hit.
4. Same as 3 with ball_y=98 (rel 0, top), y_dir=1 → y_dir=0, vy=4.
5. ball_x=629, vx=2, right, ball_y=100, right_paddle_y=300 → lhs_scored, state SCORED, ball frozen for 30 ticks. Then ball (320,240), x_dir=0, vx=vy=1, PLAY.
6. Deassert enable for 5 frame_ticks → no change. Assert resetn=0 mid-SCORED between clock edges → outputs at reset values before the next clk edge.
